tx_packet_sequencer: RTL and testbench

- Sequences every outgoing USB packet for the endpoint.
- Accepts the host-written TX control command and validates it against buffer occupancy.
- Issues a one-cycle tx_packet command to the USB TX encoder and tracks the transfer to completion, error or timeout.
- Requests the TX control register clear when the transfer finishes, and holds off new commands while a buffer flush is in progress.

---
 rtl/tx_packet_sequencer.sv | 150 +++++++++++++++
 tb/tb_tx_packet_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tx_packet_sequencer.sv
// ============================================================================
// Module      : tx_packet_sequencer
// Description : Validates the host TX command and sequences one USB packet
//               through issue, start wait, transfer and clear-back.
//               Optional statistics counters are built when TX_SEQ_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_packet_sequencer #(
  parameter int MAX_PACKET     = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_control,
  input  logic [6:0] buffer_occupancy,
  input  logic       flush_active,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [1:0] tx_packet,
  output logic       clear_tx_control,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_fail
`ifdef TX_SEQ_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] done_count,
  output logic [15:0] fail_count
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DECODE     = 3'd1,
    ISSUE      = 3'd2,
    WAIT_START = 3'd3,
    ACTIVE     = 3'd4,
    DRAIN      = 3'd5,
    DONE       = 3'd6,
    FAIL       = 3'd7
  } state_t;

  localparam logic [1:0]       c_cmd_data     = 2'd1;
  localparam logic [6:0]       c_max_packet   = 7'(MAX_PACKET);
  localparam logic [TIMER_W:0] c_timeout_last = (TIMER_W + 1)'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_cmd;
  logic               r_cmd_valid;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_next;
  logic [TIMER_W:0]   w_timer_inc;
  logic               w_launch;

  assign w_launch    = (tx_control != 8'd0) && !flush_active;
  assign w_timer_inc = {1'b0, r_timer} + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cmd       <= 2'd0;
      r_cmd_valid <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (r_state == IDLE && w_launch) begin
        r_cmd       <= tx_control[1:0];
        r_cmd_valid <= (tx_control <= 8'd3);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    case (r_state)
      IDLE: begin
        if (w_launch) w_state_next = DECODE;
      end
      DECODE: begin
        if (!r_cmd_valid)
          w_state_next = FAIL;
        else if (r_cmd == c_cmd_data && buffer_occupancy > c_max_packet)
          w_state_next = FAIL;
        else
          w_state_next = ISSUE;
      end
      ISSUE: begin
        w_timer_next = '0;
        w_state_next = WAIT_START;
      end
      WAIT_START: begin
        if (tx_transfer_active) begin
          w_state_next = ACTIVE;
        end else begin
          // Compare on the incremented value so FAIL lands TIMEOUT_CYCLES after ISSUE.
          if (r_timer != '1) w_timer_next = w_timer_inc[TIMER_W-1:0];
          if (w_timer_inc >= c_timeout_last) w_state_next = FAIL;
        end
      end
      ACTIVE: begin
        if (tx_error)
          w_state_next = DRAIN;
        else if (!tx_transfer_active)
          w_state_next = DONE;
      end
      DRAIN: begin
        if (!tx_transfer_active) w_state_next = FAIL;
      end
      DONE:    w_state_next = IDLE;
      FAIL:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign tx_packet        = (r_state == ISSUE) ? r_cmd : 2'd0;
  assign clear_tx_control = (r_state == DONE) || (r_state == FAIL);
  assign tx_busy          = (r_state != IDLE);
  assign tx_done          = (r_state == DONE);
  assign tx_fail          = (r_state == FAIL);

`ifdef TX_SEQ_STATS_EN
  logic [15:0] r_done_count;
  logic [15:0] r_fail_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_done_count <= 16'd0;
      r_fail_count <= 16'd0;
    end else if (stats_clr) begin
      r_done_count <= 16'd0;
      r_fail_count <= 16'd0;
    end else begin
      if (tx_done && r_done_count != 16'hFFFF) r_done_count <= r_done_count + 16'd1;
      if (tx_fail && r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
    end
  end

  assign done_count = r_done_count;
  assign fail_count = r_fail_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_packet_sequencer.sv
// ============================================================================
// Module      : tb_tx_packet_sequencer
// Description : Directed self-checking bench for tx_packet_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_packet_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_control;
  logic [7:0] tx_control4;
  logic [6:0] buffer_occupancy;
  logic       flush_active;
  logic       tx_transfer_active;
  logic       tx_error;

  logic [1:0] tx_packet, tx_packet4;
  logic       clear_tx_control, clear4;
  logic       tx_busy, tx_busy4;
  logic       tx_done, tx_done4;
  logic       tx_fail, tx_fail4;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tx_packet_sequencer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_control         (tx_control),
    .buffer_occupancy   (buffer_occupancy),
    .flush_active       (flush_active),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet),
    .clear_tx_control   (clear_tx_control),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_fail            (tx_fail)
  );

  tx_packet_sequencer #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_control         (tx_control4),
    .buffer_occupancy   (buffer_occupancy),
    .flush_active       (flush_active),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet4),
    .clear_tx_control   (clear4),
    .tx_busy            (tx_busy4),
    .tx_done            (tx_done4),
    .tx_fail            (tx_fail4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The host register zeroes itself the cycle after a clear request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clear_tx_control) tx_control = 8'd0;
    if (clear4) tx_control4 = 8'd0;
  endtask

  // Cycle 0 is the cycle tx_control is written; -1 means "never".
  task automatic run_case(input string name, input logic [7:0] ctl, input logic [1:0] pkt,
                          input int flush_until, input int act_lo, input int act_hi,
                          input int err_cyc, input int iss_cyc, input int done_cyc,
                          input int fail_cyc, input int ncyc);
    int end_cyc;
    end_cyc = (done_cyc > fail_cyc) ? done_cyc : fail_cyc;
    tx_control         = ctl;
    flush_active       = (0 < flush_until);
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      flush_active       = (c < flush_until);
      tx_transfer_active = (c >= act_lo) && (c <= act_hi);
      tx_error           = (c == err_cyc);
      chk($sformatf("%s pkt c%0d", name, c), 16'(tx_packet), (c == iss_cyc) ? 16'(pkt) : 16'd0);
      chk($sformatf("%s done c%0d", name, c), 16'(tx_done), 16'(c == done_cyc));
      chk($sformatf("%s fail c%0d", name, c), 16'(tx_fail), 16'(c == fail_cyc));
      chk($sformatf("%s clr c%0d", name, c), 16'(clear_tx_control),
          16'((c == done_cyc) || (c == fail_cyc)));
      if (c <= flush_until || c > end_cyc)
        chk($sformatf("%s idle c%0d", name, c), 16'(tx_busy), 16'd0);
      else if (c < end_cyc)
        chk($sformatf("%s busy c%0d", name, c), 16'(tx_busy), 16'd1);
    end
    flush_active       = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
  endtask

  initial begin
    n_rst              = 1'b0;
    tx_control         = 8'd0;
    tx_control4        = 8'd0;
    buffer_occupancy   = 7'd0;
    flush_active       = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    tick();
    tick();
    chk("rst busy", 16'(tx_busy), 16'd0);
    chk("rst pkt", 16'(tx_packet), 16'd0);
    chk("rst clr", 16'(clear_tx_control), 16'd0);
    n_rst = 1'b1;
    tick();
    chk("post-rst busy", 16'(tx_busy), 16'd0);
    chk("post-rst done", 16'(tx_done), 16'd0);
    chk("post-rst fail", 16'(tx_fail), 16'd0);

    // name, ctl, pkt, flush_until, act_lo, act_hi, err, issue, done, fail, ncyc
    run_case("ack",     8'd2, 2'd2, 0,  4, 10, -1,  2, 12,  -1,  14);
    buffer_occupancy = 7'd64;
    run_case("data64",  8'd1, 2'd1, 0,  4, 10, -1,  2, 12,  -1,  14);
    buffer_occupancy = 7'd65;
    run_case("data65",  8'd1, 2'd0, 0, -1, -1, -1, -1, -1,   2,   4);
    buffer_occupancy = 7'd0;
    run_case("data0",   8'd1, 2'd1, 0,  4, 10, -1,  2, 12,  -1,  14);
    run_case("tmo255",  8'd3, 2'd3, 0, -1, -1, -1,  2, -1, 257, 259);
    run_case("errmid",  8'd2, 2'd2, 0,  4, 11,  6,  2, -1,  13,  15);
    run_case("errfall", 8'd2, 2'd2, 0,  4, 10, 11,  2, -1,  13,  15);
    run_case("flush",   8'd2, 2'd2, 8, 12, 18, -1, 10, 20,  -1,  22);
    run_case("inval7",  8'd7, 2'd0, 0, -1, -1, -1, -1, -1,   2,   4);

    tx_control4 = 8'd3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("tmo4 fail c%0d", c), 16'(tx_fail4), 16'(c == 6));
      chk($sformatf("tmo4 pkt c%0d", c), 16'(tx_packet4), (c == 2) ? 16'd3 : 16'd0);
    end

    tx_control = 8'd2;
    for (int c = 1; c <= 6; c++) begin
      tick();
      tx_transfer_active = (c >= 4);
    end
    chk("pre-rst busy", 16'(tx_busy), 16'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst busy", 16'(tx_busy), 16'd0);
    chk("arst pkt", 16'(tx_packet), 16'd0);
    chk("arst clr", 16'(clear_tx_control), 16'd0);
    chk("arst done", 16'(tx_done), 16'd0);
    chk("arst fail", 16'(tx_fail), 16'd0);
    tx_control         = 8'd0;
    tx_transfer_active = 1'b0;
    #3;
    n_rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("after-rst pulses c%0d", c),
          16'({tx_done, tx_fail, clear_tx_control, tx_busy}), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
